gate_event_counter: RTL and testbench

Downstream stage of the gate/delay pulse generator: counts rising edges of an asynchronous detector `hit` input while the generated gate is high and reports one count record per completed gate. Records are buffered in a small first-word-fall-through FIFO and read out over a valid/ready handshake, typically by the readout/DAQ logic. Missed records and counter saturation are flagged, never silently lost.

---
 rtl/gate_event_counter.sv | 223 ++++++++++++++++++++++
 tb/tb_gate_event_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_event_counter.sv
// Counts synchronized hit edges inside each gate and queues one {count, seq[, ts]} record per gate in a FWFT FIFO.
// Optional per-gate timestamp enabled by defining GATE_TIMESTAMP_EN.
module gate_event_counter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SEQ_W      = 8,
    parameter int unsigned TS_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate,
    input  logic             hit,
    output logic [CNT_W-1:0] out_count,
    output logic [SEQ_W-1:0] out_seq,
`ifdef GATE_TIMESTAMP_EN
    output logic [TS_W-1:0]  out_ts,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             dropped,
    input  logic             clr_flags
);

`ifdef GATE_TIMESTAMP_EN
    localparam int unsigned TS_FIELD_W = TS_W;
`else
    localparam int unsigned TS_FIELD_W = TS_W - TS_W;
`endif
    localparam int unsigned REC_W = CNT_W + SEQ_W + TS_FIELD_W;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_hit_meta;
    logic r_hit_sync;
    logic r_hit_prev;
    logic w_hit_edge;

    logic r_gate_d;
    logic w_gate_rise;
    logic w_gate_fall;

    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] w_acc_next;
    logic [SEQ_W-1:0] r_seq;
    logic             w_push;
    logic             w_ovf_set;

    logic [REC_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [REC_W-1:0] w_wr_word;
    logic [REC_W-1:0] w_rd_word;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop_set;

    logic r_overflow;
    logic r_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_meta <= 1'b0;
            r_hit_sync <= 1'b0;
            r_hit_prev <= 1'b0;
        end else begin
            r_hit_meta <= hit;
            r_hit_sync <= r_hit_meta;
            r_hit_prev <= r_hit_sync;
        end
    end

    assign w_hit_edge = r_hit_sync & ~r_hit_prev;

    // gate_d resets high so a gate already asserted at reset release is not a rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_d <= 1'b1;
        end else begin
            r_gate_d <= gate;
        end
    end

    assign w_gate_rise = gate & ~r_gate_d;
    assign w_gate_fall = ~gate & r_gate_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_push       = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gate_rise) begin
                    w_state_next = COUNT;
                    w_acc_next   = {{(CNT_W-1){1'b0}}, w_hit_edge};
                end
            end
            COUNT: begin
                if (w_gate_fall) begin
                    w_state_next = IDLE;
                    w_push       = 1'b1;
                end else if (gate && w_hit_edge) begin
                    if (r_acc == '1) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_acc_next = r_acc + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_seq <= '0;
        end else begin
            r_acc <= w_acc_next;
            if (w_push) begin
                r_seq <= r_seq + 1'b1;
            end
        end
    end

`ifdef GATE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts_gate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt  <= '0;
            r_ts_gate <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_gate_rise) begin
                r_ts_gate <= r_ts_cnt;
            end
        end
    end

    assign w_wr_word = {r_ts_gate, r_seq, r_acc};
    assign out_ts    = w_rd_word[CNT_W+SEQ_W +: TS_W];
`else
    assign w_wr_word = {r_seq, r_acc};
`endif

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = ~w_empty & out_ready;
    // A full FIFO still accepts the record when the head leaves in the same cycle
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_drop_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
    assign out_count = w_rd_word[CNT_W-1:0];
    assign out_seq   = w_rd_word[CNT_W +: SEQ_W];
    assign out_valid = ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_drop_set) begin
                r_dropped <= 1'b1;
            end else if (clr_flags) begin
                r_dropped <= 1'b0;
            end
        end
    end

    assign overflow = r_overflow;
    assign dropped  = r_dropped;

endmodule

// File: tb/tb_gate_event_counter.sv
// Directed bench for gate_event_counter with a record scoreboard (CNT_W=4, FIFO_DEPTH=4).
module tb_gate_event_counter;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SEQ_W   = 8;
    localparam int unsigned TS_W    = 32;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             gate      = 1'b0;
    logic             hit       = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_flags = 1'b0;
    logic [CNT_W-1:0] out_count;
    logic [SEQ_W-1:0] out_seq;
    logic             out_valid;
    logic             overflow;
    logic             dropped;

    gate_event_counter #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (DEPTH),
        .SEQ_W      (SEQ_W),
        .TS_W       (TS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gate      (gate),
        .hit       (hit),
        .out_count (out_count),
        .out_seq   (out_seq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .dropped   (dropped),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    rec_t        sb[$];
    int          checks    = 0;
    int          errors    = 0;
    int unsigned model_seq = 0;
    logic        exp_drop  = 1'b0;
    logic        exp_ovf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds gate high for 'high' cycles with n clean hit pulses (4 high / 6 low), then drops gate.
    task automatic run_gate(input int unsigned n, input int unsigned high);
        rec_t r;
        gate = 1'b1;
        for (int unsigned c = 0; c < high; c++) begin
            hit = (c >= 4) && ((c - 4) / 10 < n) && ((c - 4) % 10 < 4);
            tick();
        end
        gate = 1'b0;
        hit  = 1'b0;
        r.cnt = (n > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n);
        r.seq = SEQ_W'(model_seq);
        model_seq++;
        if (n > CNT_MAX) exp_ovf = 1'b1;
        if (sb.size() < DEPTH) sb.push_back(r);
        else exp_drop = 1'b1;
    endtask

    task automatic drain(input string tag);
        int unsigned budget = 64;
        rec_t e;
        out_ready = 1'b1;
        while (sb.size() > 0 && budget > 0) begin
            if (out_valid) begin
                e = sb.pop_front();
                check({tag, "_count"}, 32'(out_count), 32'(e.cnt));
                check({tag, "_seq"}, 32'(out_seq), 32'(e.seq));
            end
            tick();
            budget--;
        end
        check({tag, "_left"}, 32'(sb.size()), 32'd0);
        out_ready = 1'b0;
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_seq", 32'(out_seq), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(dropped), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // one long gate, 7 hits, record appears one cycle after gate fall
        run_gate(7, 100);
        check("t1_valid_pre", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid_post", 32'(out_valid), 32'd1);
        tick(2);
        drain("t1");

        // three gates stalled, then drained in order
        run_gate(0, 12);
        tick(2);
        run_gate(1, 22);
        tick(2);
        run_gate(5, 62);
        tick(2);
        check("t2_valid", 32'(out_valid), 32'd1);
        tick(3);
        check("t2_stall_valid", 32'(out_valid), 32'd1);
        check("t2_stall_count", 32'(out_count), 32'(sb[0].cnt));
        check("t2_stall_seq", 32'(out_seq), 32'(sb[0].seq));
        drain("t2");

        // six gates into a four-deep FIFO
        for (int k = 0; k < 6; k++) begin
            run_gate(1, 22);
            tick(2);
        end
        check("t3_dropped", 32'(dropped), 32'(exp_drop));
        drain("t3");
        run_gate(2, 32);
        tick(2);
        drain("t3_gap");

        // saturation
        check("t4_ovf_pre", 32'(overflow), 32'(exp_ovf));
        run_gate(20, 214);
        tick(2);
        check("t4_ovf", 32'(overflow), 32'(exp_ovf));
        drain("t4");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        exp_ovf  = 1'b0;
        exp_drop = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'(exp_ovf));
        check("t4_drop_clr", 32'(dropped), 32'(exp_drop));

        // reset mid-gate with two records queued
        run_gate(1, 22);
        tick(2);
        run_gate(2, 32);
        tick(2);
        check("t5_queued", 32'(out_valid), 32'd1);
        gate = 1'b1;
        hit  = 1'b1;
        tick(4);
        hit   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        sb.delete();
        model_seq = 0;
        tick(4);
        hit = 1'b1;
        tick(4);
        hit = 1'b0;
        tick(6);
        gate = 1'b0;
        tick(4);
        check("t5_no_rec", 32'(out_valid), 32'd0);
        check("t5_seq0", 32'(out_seq), 32'd0);
        run_gate(3, 42);
        tick();
        check("t5_next_valid", 32'(out_valid), 32'd1);
        drain("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
